load_store_unit: RTL and testbench

- Initiator side of the data-memory port, placed in the MEM stage between the pipeline and the data memory.
- Accepts one load/store request at a time through a valid/ready handshake.
- Computes the effective address and rejects misaligned or out-of-range accesses.
- Drives the memory's 2-bit MemWrite/MemRead access-size codes, captures the negedge-registered read data, applies zero-extension for unsigned loads, and returns the result through a second valid/ready handshake.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_addr_check.sv | 38 +++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: request opcodes, memory access-size
// codes, fault codes and the FSM state type.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'b00,
    SIZE_WORD = 2'b01,
    SIZE_HALF = 2'b10,
    SIZE_BYTE = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  function automatic logic isStore(input lsu_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic access_size_e opSize(input lsu_op_e op);
    case (op)
      OP_LW, OP_SW:         return SIZE_WORD;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational effective-address generation plus alignment and range checks.
// Misalignment is reported in preference to an out-of-range address.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       offset,
  input  logic [2:0]        op,
  output logic [ADDR_W-1:0] effAddr,
  output logic [1:0]        sizeCode,
  output logic [1:0]        faultCode
);

  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  access_size_e sizeE;
  logic         misaligned;
  logic         outOfRange;

  always_comb begin
    effAddr    = base + {{(ADDR_W-16){offset[15]}}, offset};
    sizeE      = opSize(lsu_op_e'(op));
    misaligned = ((sizeE == SIZE_WORD) && (effAddr[1:0] != 2'b00)) ||
                 ((sizeE == SIZE_HALF) && effAddr[0]);
    outOfRange = (effAddr[ADDR_W-1:2] >= WORD_LIMIT);
    sizeCode   = sizeE;
    if (misaligned)
      faultCode = FAULT_MISALIGN;
    else if (outOfRange)
      faultCode = FAULT_RANGE;
    else
      faultCode = FAULT_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one request, performs a single-cycle
// data-memory access, and returns the (zero-extended where needed) result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        ReqOp,
  input  logic [ADDR_W-1:0] ReqBase,
  input  logic [15:0]       ReqOffset,
  input  logic [ADDR_W-1:0] ReqData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [ADDR_W-1:0] RespData,
  output logic [1:0]        RespFault,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [ADDR_W-1:0] MemWriteData,
  output logic [1:0]        MemWrite,
  output logic [1:0]        MemRead,
  input  logic [ADDR_W-1:0] MemReadData
);

  lsu_state_e        state, nextState;
  lsu_op_e           opReg;
  logic [1:0]        sizeReg;
  logic [ADDR_W-1:0] checkAddr;
  logic [1:0]        checkSize;
  logic [1:0]        checkFault;
  logic              accept;
  logic [ADDR_W-1:0] loadResult;

  lsu_addr_check #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) uAddrCheck (
    .base     (ReqBase),
    .offset   (ReqOffset),
    .op       (ReqOp),
    .effAddr  (checkAddr),
    .sizeCode (checkSize),
    .faultCode(checkFault)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      state <= ST_IDLE;
    else
      state <= nextState;
  end

  // Memory strobes are decoded from state so an asynchronous reset during
  // ACCESS drops MemWrite immediately and no store commits.
  always_comb begin
    nextState = state;
    ReqReady  = 1'b0;
    RespValid = 1'b0;
    MemWrite  = SIZE_NONE;
    MemRead   = SIZE_NONE;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        ReqReady = Rst_n;
        if (ReqValid) begin
          accept    = 1'b1;
          nextState = (checkFault != FAULT_NONE) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (isStore(opReg))
          MemWrite = sizeReg;
        else
          MemRead = sizeReg;
        nextState = ST_RESP;
      end
      ST_RESP: begin
        RespValid = 1'b1;
        if (RespReady)
          nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // The memory already sign-extends, so only the unsigned loads need masking.
  always_comb begin
    loadResult = MemReadData;
    case (opReg)
      OP_LHU:              loadResult = {{(ADDR_W-16){1'b0}}, MemReadData[15:0]};
      OP_LBU:              loadResult = {{(ADDR_W-8){1'b0}}, MemReadData[7:0]};
      OP_SW, OP_SH, OP_SB: loadResult = '0;
      default:             loadResult = MemReadData;
    endcase
  end

  // Faulting requests never touch the memory port, so its address/data hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opReg        <= OP_LW;
      sizeReg      <= SIZE_NONE;
      MemAddress   <= '0;
      MemWriteData <= '0;
      RespData     <= '0;
      RespFault    <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opReg     <= lsu_op_e'(ReqOp);
            sizeReg   <= checkSize;
            RespFault <= checkFault;
            RespData  <= '0;
            if (checkFault == FAULT_NONE) begin
              MemAddress   <= checkAddr;
              MemWriteData <= ReqData;
            end
          end
        end
        ST_ACCESS: RespData <= loadResult;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data memory that
// commits stores on the rising edge and registers sign-extended reads on the falling edge.
module tb_load_store_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  logic        Clk, Rst_n;
  logic        ReqValid, ReqReady;
  logic [2:0]  ReqOp;
  logic [31:0] ReqBase;
  logic [15:0] ReqOffset;
  logic [31:0] ReqData;
  logic        RespValid, RespReady;
  logic [31:0] RespData;
  logic [1:0]  RespFault;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic [1:0]  MemWrite, MemRead;

  logic [31:0] mem [0:1023];
  logic [31:0] rdWord;
  logic [15:0] rdHalf;
  logic [7:0]  rdByte;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount  = 0;

  load_store_unit #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqBase(ReqBase), .ReqOffset(ReqOffset), .ReqData(ReqData),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespFault(RespFault),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    case (MemWrite)
      2'b01: mem[MemAddress[11:2]] <= MemWriteData;
      2'b10: mem[MemAddress[11:2]][{MemAddress[1], 4'b0000} +: 16] <= MemWriteData[15:0];
      2'b11: mem[MemAddress[11:2]][{MemAddress[1:0], 3'b000} +: 8] <= MemWriteData[7:0];
      default: ;
    endcase
  end

  always @(negedge Clk) begin
    rdWord = mem[MemAddress[11:2]];
    rdHalf = rdWord[{MemAddress[1], 4'b0000} +: 16];
    rdByte = rdWord[{MemAddress[1:0], 3'b000} +: 8];
    case (MemRead)
      2'b01: MemReadData <= rdWord;
      2'b10: MemReadData <= {{16{rdHalf[15]}}, rdHalf};
      2'b11: MemReadData <= {{24{rdByte[7]}}, rdByte};
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n && RespValid && RespReady) begin
      if (expQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpectedResp: got data 0x%08h fault %0d, expected none",
                 RespData, RespFault);
      end else begin
        e = expQ.pop_front();
        checkOutput("respData", RespData, e.data);
        checkOutput("respFault", {30'b0, RespFault}, {30'b0, e.fault});
      end
    end
  end

  // Returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] base,
                               input logic [15:0] offset, input logic [31:0] data,
                               input logic [31:0] expData, input logic [1:0] expFault,
                               input bit expectResp);
    int waitCycles = 0;
    while (!ReqReady && waitCycles < 20) begin
      @(posedge Clk); #1;
      waitCycles++;
    end
    if (!ReqReady) begin
      checkOutput("reqReadyTimeout", {31'b0, ReqReady}, 32'd1);
      return;
    end
    ReqValid  = 1'b1;
    ReqOp     = op;
    ReqBase   = base;
    ReqOffset = offset;
    ReqData   = data;
    if (expectResp) expQ.push_back('{data: expData, fault: expFault});
    @(posedge Clk); #1;
    ReqValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL respTimeout: got %0d pending responses, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    MemReadData = 32'h0;
    Rst_n = 1'b0; ReqValid = 1'b0; ReqOp = 3'd0; ReqBase = 32'h0;
    ReqOffset = 16'h0; ReqData = 32'h0; RespReady = 1'b1;

    @(posedge Clk); @(posedge Clk); #1;
    checkOutput("rstReqReady", {31'b0, ReqReady}, 32'd0);
    checkOutput("rstRespValid", {31'b0, RespValid}, 32'd0);
    checkOutput("rstRespData", RespData, 32'h0);
    checkOutput("rstMemAddress", MemAddress, 32'h0);
    checkOutput("rstMemStrobes", {28'b0, MemWrite, MemRead}, 32'h0);
    Rst_n = 1'b1;
    #1;
    checkOutput("idleReqReady", {31'b0, ReqReady}, 32'd1);

    // Word store then load back.
    applyStimulus(SW, 32'h10, 16'd4, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
    checkOutput("swMemWrite", {30'b0, MemWrite}, 32'd1);
    checkOutput("swMemAddress", MemAddress, 32'h14);
    checkOutput("swMemWriteData", MemWriteData, 32'hDEADBEEF);
    @(posedge Clk); #1;
    checkOutput("swMemWriteOff", {30'b0, MemWrite}, 32'd0);
    waitDrain();
    applyStimulus(LW, 32'h14, 16'd0, 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    checkOutput("lwMemRead", {30'b0, MemRead}, 32'd1);
    waitDrain();

    // Halfword store to the upper half, signed and unsigned loads.
    applyStimulus(SH, 32'h20, 16'd2, 32'h1234ABCD, 32'h0, 2'b00, 1'b1);
    checkOutput("shMemWrite", {30'b0, MemWrite}, 32'd2);
    waitDrain();
    applyStimulus(LH, 32'h22, 16'd0, 32'h0, 32'hFFFFABCD, 2'b00, 1'b1);
    waitDrain();
    applyStimulus(LHU, 32'h22, 16'd0, 32'h0, 32'h0000ABCD, 2'b00, 1'b1);
    waitDrain();

    // Byte store and loads.
    applyStimulus(SB, 32'h30, 16'd3, 32'h00000080, 32'h0, 2'b00, 1'b1);
    checkOutput("sbMemWrite", {30'b0, MemWrite}, 32'd3);
    waitDrain();
    applyStimulus(LB, 32'h33, 16'd0, 32'h0, 32'hFFFFFF80, 2'b00, 1'b1);
    waitDrain();
    applyStimulus(LBU, 32'h33, 16'd0, 32'h0, 32'h00000080, 2'b00, 1'b1);
    waitDrain();

    // Faults: misaligned word, out of range, priority, misaligned half, top word ok.
    applyStimulus(LW, 32'h06, 16'd0, 32'h0, 32'h0, 2'b01, 1'b1);
    checkOutput("faultRespValid", {31'b0, RespValid}, 32'd1);
    checkOutput("faultMemRead", {30'b0, MemRead}, 32'd0);
    waitDrain();
    applyStimulus(LW, 32'h1000, 16'd0, 32'h0, 32'h0, 2'b10, 1'b1);
    waitDrain();
    applyStimulus(LW, 32'h1000, 16'd2, 32'h0, 32'h0, 2'b01, 1'b1);
    waitDrain();
    applyStimulus(SH, 32'h20, 16'd1, 32'h5555, 32'h0, 2'b01, 1'b1);
    checkOutput("shFaultNoWrite", {30'b0, MemWrite}, 32'd0);
    waitDrain();
    applyStimulus(LW, 32'hFFC, 16'd0, 32'h0, 32'h0, 2'b00, 1'b1);
    waitDrain();

    // Negative offset.
    applyStimulus(SW, 32'h8, 16'hFFFC, 32'hCAFEF00D, 32'h0, 2'b00, 1'b1);
    checkOutput("negOffAddress", MemAddress, 32'h4);
    waitDrain();
    applyStimulus(LW, 32'h8, 16'hFFFC, 32'h0, 32'hCAFEF00D, 2'b00, 1'b1);
    waitDrain();

    // Response back-pressure, with a request presented while busy.
    RespReady = 1'b0;
    applyStimulus(LW, 32'h14, 16'd0, 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    @(posedge Clk); #1;
    ReqValid = 1'b1; ReqOp = SW; ReqBase = 32'h100; ReqOffset = 16'd0; ReqData = 32'h77;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallRespValid", {31'b0, RespValid}, 32'd1);
      checkOutput("stallRespData", RespData, 32'hDEADBEEF);
      checkOutput("stallReqReady", {31'b0, ReqReady}, 32'd0);
      @(posedge Clk); #1;
    end
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    waitDrain();
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("ignoredReqMem", mem[64], 32'h0);

    // Reset in the middle of a store's ACCESS cycle.
    applyStimulus(SW, 32'h40, 16'd0, 32'h00000055, 32'h0, 2'b00, 1'b0);
    checkOutput("midRstPreWrite", {30'b0, MemWrite}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("midRstMemWrite", {30'b0, MemWrite}, 32'd0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst_n = 1'b1;
    #1;
    checkOutput("midRstMemUnchanged", mem[16], 32'h0);
    checkOutput("midRstIdle", {31'b0, ReqReady}, 32'd1);
    checkOutput("midRstRespValid", {31'b0, RespValid}, 32'd0);
    applyStimulus(LW, 32'h40, 16'd0, 32'h0, 32'h0, 2'b00, 1'b1);
    waitDrain();

    repeat (4) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
